// File: rtl/gameconsole_pkg.sv
// Shared VPU/console types and constants used across the video pipeline.
package gameconsole_pkg;

   // Tile RAM geometry
   localparam int unsigned TILE_ADDR_W = 16;
   localparam int unsigned TILE_DATA_W = 32;

   // Waiting cycles after which a pending CPU VRAM access is force-granted
   localparam int unsigned VRAM_CPU_STARVE_MAX = 15;

   // Tile RAM requester identity, carried with each read to route its data
   typedef enum logic [1:0] {
      REQ_BG  = 2'd0,
      REQ_SP  = 2'd1,
      REQ_CPU = 2'd2
   } vram_req_id_e;

endpackage : gameconsole_pkg

// File: rtl/vpu_rd_tag_pipe.sv
// Read-response tag pipeline: follows each tile RAM read from grant to data
// return and raises the rvalid of the requester that issued it.
module vpu_rd_tag_pipe
   import gameconsole_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  vram_req_id_e i_push_id,
   output logic         o_bg_rvalid,
   output logic         o_sp_rvalid,
   output logic         o_cpu_rvalid
);

   // Stage 0 lines up with the command cycle; stage RD_LAT with returned data.
   logic [RD_LAT:0] r_vld;
   vram_req_id_e    r_id [RD_LAT+1];

   // Shift the tag pipe; reset drops every in-flight read
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld <= '0;
         for (int unsigned i = 0; i <= RD_LAT; i++) begin
            r_id[i] <= REQ_BG;
         end
      end else begin
         r_vld[0] <= i_push;
         r_id[0]  <= i_push_id;
         for (int unsigned i = 1; i <= RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_id[i]  <= r_id[i-1];
         end
      end
   end

   assign o_bg_rvalid  = r_vld[RD_LAT] && (r_id[RD_LAT] == REQ_BG);
   assign o_sp_rvalid  = r_vld[RD_LAT] && (r_id[RD_LAT] == REQ_SP);
   assign o_cpu_rvalid = r_vld[RD_LAT] && (r_id[RD_LAT] == REQ_CPU);

endmodule : vpu_rd_tag_pipe

// File: rtl/vpu_tile_arbiter.sv
// Tile RAM arbiter: shares one single-port tile RAM between the BG fetcher,
// the sprite fetcher and the CPU VRAM window. Fetchers win during active
// display (with a CPU starvation guard), the CPU wins during vblank.
module vpu_tile_arbiter
   import gameconsole_pkg::*;
#(
   parameter int unsigned ADDR_W         = TILE_ADDR_W,
   parameter int unsigned DATA_W         = TILE_DATA_W,
   parameter int unsigned RD_LAT         = 1,
   parameter int unsigned CPU_STARVE_MAX = VRAM_CPU_STARVE_MAX
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_vblank,
   // BG fetcher
   input  logic              i_bg_req,
   input  logic [ADDR_W-1:0] i_bg_addr,
   output logic              o_bg_gnt,
   output logic              o_bg_rvalid,
   output logic [DATA_W-1:0] o_bg_rdata,
   // Sprite fetcher
   input  logic              i_sp_req,
   input  logic [ADDR_W-1:0] i_sp_addr,
   output logic              o_sp_gnt,
   output logic              o_sp_rvalid,
   output logic [DATA_W-1:0] o_sp_rdata,
   // CPU VRAM window
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_gnt,
   output logic              o_cpu_rvalid,
   output logic [DATA_W-1:0] o_cpu_rdata,
   // Tile RAM macro
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_dout
);

   localparam int unsigned STARVE_W =
      (CPU_STARVE_MAX < 1) ? 1 : $clog2(CPU_STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(CPU_STARVE_MAX);

   logic                r_rr;            // 0 = BG favoured, 1 = SP favoured
   logic [STARVE_W-1:0] r_starve_cnt;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;

   logic         w_force_cpu;
   logic         w_rr_bg;
   logic         w_rr_sp;
   logic         w_bg_gnt;
   logic         w_sp_gnt;
   logic         w_cpu_gnt;
   logic         w_push;
   vram_req_id_e w_push_id;

   // BG/SP round-robin pick; a lone requester wins regardless of the pointer
   assign w_rr_bg = i_bg_req && (!i_sp_req || !r_rr);
   assign w_rr_sp = i_sp_req && (!i_bg_req ||  r_rr);

   assign w_force_cpu = i_cpu_req && (r_starve_cnt == STARVE_MAX_C);

   // Phase-dependent priority select, one grant at most, none during reset
   always_comb begin
      w_bg_gnt  = 1'b0;
      w_sp_gnt  = 1'b0;
      w_cpu_gnt = 1'b0;
      if (!i_rst) begin
         if (i_vblank) begin
            if (i_cpu_req)    w_cpu_gnt = 1'b1;
            else if (w_rr_bg) w_bg_gnt  = 1'b1;
            else if (w_rr_sp) w_sp_gnt  = 1'b1;
         end else begin
            if (w_force_cpu)    w_cpu_gnt = 1'b1;
            else if (w_rr_bg)   w_bg_gnt  = 1'b1;
            else if (w_rr_sp)   w_sp_gnt  = 1'b1;
            else if (i_cpu_req) w_cpu_gnt = 1'b1;
         end
      end
   end

   // Round-robin pointer and CPU starvation counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr         <= 1'b0;
         r_starve_cnt <= '0;
      end else begin
         if (w_bg_gnt)      r_rr <= 1'b1;
         else if (w_sp_gnt) r_rr <= 1'b0;

         if (!i_cpu_req || w_cpu_gnt)
            r_starve_cnt <= '0;
         else if (r_starve_cnt != STARVE_MAX_C)
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end
   end

   // Registered RAM command stage; address and write data hold when idle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en <= w_bg_gnt || w_sp_gnt || w_cpu_gnt;
         r_mem_we <= w_cpu_gnt && i_cpu_we;
         if (w_bg_gnt) r_mem_addr <= i_bg_addr;
         if (w_sp_gnt) r_mem_addr <= i_sp_addr;
         if (w_cpu_gnt) begin
            r_mem_addr  <= i_cpu_addr;
            r_mem_wdata <= i_cpu_wdata;
         end
      end
   end

   // Only reads travel down the tag pipe; CPU writes never return data
   assign w_push    = w_bg_gnt || w_sp_gnt || (w_cpu_gnt && !i_cpu_we);
   assign w_push_id = w_sp_gnt ? REQ_SP : (w_cpu_gnt ? REQ_CPU : REQ_BG);

   vpu_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_push       (w_push),
      .i_push_id    (w_push_id),
      .o_bg_rvalid  (o_bg_rvalid),
      .o_sp_rvalid  (o_sp_rvalid),
      .o_cpu_rvalid (o_cpu_rvalid)
   );

   assign o_bg_gnt    = w_bg_gnt;
   assign o_sp_gnt    = w_sp_gnt;
   assign o_cpu_gnt   = w_cpu_gnt;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_bg_rdata  = i_mem_dout;
   assign o_sp_rdata  = i_mem_dout;
   assign o_cpu_rdata = i_mem_dout;

endmodule : vpu_tile_arbiter

// File: tb/tb_vpu_tile_arbiter.sv
// Directed self-checking bench for vpu_tile_arbiter (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the falling edge of the same cycle.
module tb_vpu_tile_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        vblank;
   logic        bg_req, sp_req, cpu_req, cpu_we;
   logic [15:0] bg_addr, sp_addr, cpu_addr;
   logic [31:0] cpu_wdata, mem_dout;
   logic        bg_gnt, sp_gnt, cpu_gnt;
   logic        bg_rvalid, sp_rvalid, cpu_rvalid;
   logic [31:0] bg_rdata, sp_rdata, cpu_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vpu_tile_arbiter dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_vblank     (vblank),
      .i_bg_req     (bg_req),
      .i_bg_addr    (bg_addr),
      .o_bg_gnt     (bg_gnt),
      .o_bg_rvalid  (bg_rvalid),
      .o_bg_rdata   (bg_rdata),
      .i_sp_req     (sp_req),
      .i_sp_addr    (sp_addr),
      .o_sp_gnt     (sp_gnt),
      .o_sp_rvalid  (sp_rvalid),
      .o_sp_rdata   (sp_rdata),
      .i_cpu_req    (cpu_req),
      .i_cpu_we     (cpu_we),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_wdata  (cpu_wdata),
      .o_cpu_gnt    (cpu_gnt),
      .o_cpu_rvalid (cpu_rvalid),
      .o_cpu_rdata  (cpu_rdata),
      .o_mem_en     (mem_en),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_dout   (mem_dout)
   );

   // advance to the start of the next cycle (1 unit after the rising edge)
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // move to the sampling point of the current cycle
   task automatic sample();
      #4;
   endtask

   task automatic idle_inputs();
      vblank = 1'b0; bg_req = 1'b0; sp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      bg_addr = '0; sp_addr = '0; cpu_addr = '0; cpu_wdata = '0; mem_dout = '0;
   endtask

   // two reset cycles; returns at the start of the first cycle out of reset
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      bg_req = 1'b1; sp_req = 1'b1; cpu_req = 1'b1;
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt, cpu_gnt} !== 3'b000) begin
         n_err++; $display("FAIL reset_gnt: got %b want 000", {bg_gnt, sp_gnt, cpu_gnt});
      end
      n_vec++;
      if ({mem_en, mem_we, bg_rvalid, sp_rvalid, cpu_rvalid} !== 5'b00000) begin
         n_err++; $display("FAIL reset_ctl: got %b want 00000",
                           {mem_en, mem_we, bg_rvalid, sp_rvalid, cpu_rvalid});
      end
      n_vec++;
      if (mem_addr !== 16'h0000 || mem_wdata !== 32'h0) begin
         n_err++; $display("FAIL reset_bus: got addr %h wdata %h want 0 0", mem_addr, mem_wdata);
      end
      n_vec++;
      if (dut.r_starve_cnt !== 4'd0 || dut.r_rr !== 1'b0) begin
         n_err++; $display("FAIL reset_state: got starve %0d rr %b want 0 0",
                           dut.r_starve_cnt, dut.r_rr);
      end
      tick();
      idle_inputs();
      rst = 1'b0;
   endtask

   task automatic test_bg_read();
      do_reset();
      bg_req = 1'b1; bg_addr = 16'h0123; mem_dout = 32'hDEADBEEF;
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt, cpu_gnt} !== 3'b100) begin
         n_err++; $display("FAIL bg_gnt_c0: got %b want 100", {bg_gnt, sp_gnt, cpu_gnt});
      end
      tick();
      bg_req = 1'b0;
      sample();
      n_vec++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0123) begin
         n_err++; $display("FAIL bg_cmd_c1: got en %b we %b addr %h want 1 0 0123",
                           mem_en, mem_we, mem_addr);
      end
      n_vec++;
      if (bg_rvalid !== 1'b0) begin
         n_err++; $display("FAIL bg_early_rvalid: got %b want 0", bg_rvalid);
      end
      tick();
      sample();
      n_vec++;
      if (bg_rvalid !== 1'b1 || bg_rdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL bg_rdata_c2: got v %b d %h want 1 deadbeef", bg_rvalid, bg_rdata);
      end
      n_vec++;
      if (sp_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || mem_en !== 1'b0) begin
         n_err++; $display("FAIL bg_others_c2: got sp %b cpu %b en %b want 0 0 0",
                           sp_rvalid, cpu_rvalid, mem_en);
      end
      tick();
      sample();
      n_vec++;
      if (bg_rvalid !== 1'b0) begin
         n_err++; $display("FAIL bg_rvalid_pulse: got %b want 0", bg_rvalid);
      end
   endtask

   task automatic test_single_requester();
      do_reset();
      sp_req = 1'b1; sp_addr = 16'h0200;
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt} !== 2'b01) begin
         n_err++; $display("FAIL lone_sp: got %b want 01", {bg_gnt, sp_gnt});
      end
      tick();
      sp_req = 1'b0; bg_req = 1'b1; bg_addr = 16'h0100;
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt} !== 2'b10) begin
         n_err++; $display("FAIL lone_bg: got %b want 10", {bg_gnt, sp_gnt});
      end
      tick();
      sp_req = 1'b1;
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt} !== 2'b01) begin
         n_err++; $display("FAIL rr_after_bg: got %b want 01", {bg_gnt, sp_gnt});
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_round_robin();
      logic e_bg, e_sp, e_bgv, e_spv;
      logic [15:0] e_addr;
      do_reset();
      bg_addr = 16'h0100; sp_addr = 16'h0200;
      for (int c = 0; c < 9; c++) begin
         bg_req = (c < 6); sp_req = (c < 6);
         e_bg  = (c < 6) && (c % 2 == 0);
         e_sp  = (c < 6) && (c % 2 == 1);
         e_bgv = (c >= 2) && (c < 8) && (c % 2 == 0);
         e_spv = (c >= 2) && (c < 8) && (c % 2 == 1);
         e_addr = (c >= 1 && (c - 1) % 2 == 1) ? 16'h0200 : 16'h0100;
         sample();
         n_vec++;
         if ({bg_gnt, sp_gnt, cpu_gnt} !== {e_bg, e_sp, 1'b0}) begin
            n_err++; $display("FAIL rr_gnt c%0d: got %b want %b", c,
                              {bg_gnt, sp_gnt, cpu_gnt}, {e_bg, e_sp, 1'b0});
         end
         n_vec++;
         if ({bg_rvalid, sp_rvalid} !== {e_bgv, e_spv}) begin
            n_err++; $display("FAIL rr_rvalid c%0d: got %b want %b", c,
                              {bg_rvalid, sp_rvalid}, {e_bgv, e_spv});
         end
         if (c >= 1 && c <= 6) begin
            n_vec++;
            if (mem_en !== 1'b1 || mem_addr !== e_addr) begin
               n_err++; $display("FAIL rr_cmd c%0d: got en %b addr %h want 1 %h", c,
                                 mem_en, mem_addr, e_addr);
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      logic e_bg, e_sp, e_cpu;
      do_reset();
      bg_addr = 16'h0100; sp_addr = 16'h0200; cpu_addr = 16'h0777;
      bg_req = 1'b1; sp_req = 1'b1; cpu_req = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c == 16) cpu_req = 1'b0;
         e_cpu = (c == 15);
         e_bg  = ((c < 15) && (c % 2 == 0)) || (c == 17);
         e_sp  = ((c < 15) && (c % 2 == 1)) || (c == 16);
         sample();
         n_vec++;
         if ({bg_gnt, sp_gnt, cpu_gnt} !== {e_bg, e_sp, e_cpu}) begin
            n_err++; $display("FAIL starve_gnt c%0d: got %b want %b", c,
                              {bg_gnt, sp_gnt, cpu_gnt}, {e_bg, e_sp, e_cpu});
         end
         if (c == 14 || c == 16) begin
            n_vec++;
            if (dut.r_starve_cnt !== ((c == 14) ? 4'd14 : 4'd0)) begin
               n_err++; $display("FAIL starve_cnt c%0d: got %0d want %0d", c,
                                 dut.r_starve_cnt, (c == 14) ? 14 : 0);
            end
         end
         if (c == 16) begin
            n_vec++;
            if (mem_addr !== 16'h0777 || mem_en !== 1'b1) begin
               n_err++; $display("FAIL starve_cmd: got en %b addr %h want 1 0777", mem_en, mem_addr);
            end
         end
         if (c == 17) begin
            n_vec++;
            if (cpu_rvalid !== 1'b1 || bg_rvalid !== 1'b0 || sp_rvalid !== 1'b0) begin
               n_err++; $display("FAIL starve_rvalid: got cpu %b bg %b sp %b want 1 0 0",
                                 cpu_rvalid, bg_rvalid, sp_rvalid);
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_vblank_cpu();
      do_reset();
      vblank = 1'b1; mem_dout = 32'hCAFEF00D;
      bg_req = 1'b1; sp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
      bg_addr = 16'h0100; sp_addr = 16'h0200; cpu_addr = 16'h0040;
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt, cpu_gnt} !== 3'b001) begin
         n_err++; $display("FAIL vb_gnt_c0: got %b want 001", {bg_gnt, sp_gnt, cpu_gnt});
      end
      tick();
      cpu_addr = 16'h0044;                 // second back-to-back CPU read
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt, cpu_gnt} !== 3'b001 || mem_addr !== 16'h0040) begin
         n_err++; $display("FAIL vb_c1: got gnt %b addr %h want 001 0040",
                           {bg_gnt, sp_gnt, cpu_gnt}, mem_addr);
      end
      tick();
      cpu_req = 1'b0;
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt, cpu_gnt} !== 3'b100 || mem_addr !== 16'h0044) begin
         n_err++; $display("FAIL vb_c2: got gnt %b addr %h want 100 0044",
                           {bg_gnt, sp_gnt, cpu_gnt}, mem_addr);
      end
      n_vec++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFEF00D || bg_rvalid !== 1'b0) begin
         n_err++; $display("FAIL vb_cpu_rdata: got v %b d %h bgv %b want 1 cafef00d 0",
                           cpu_rvalid, cpu_rdata, bg_rvalid);
      end
      tick();
      sample();
      n_vec++;
      if ({bg_gnt, sp_gnt, cpu_gnt} !== 3'b010 || cpu_rvalid !== 1'b1) begin
         n_err++; $display("FAIL vb_c3: got gnt %b cpuv %b want 010 1",
                           {bg_gnt, sp_gnt, cpu_gnt}, cpu_rvalid);
      end
      tick();
      bg_req = 1'b0; sp_req = 1'b0;
      sample();
      n_vec++;
      if ({bg_rvalid, sp_rvalid, cpu_rvalid} !== 3'b100) begin
         n_err++; $display("FAIL vb_c4_rvalid: got %b want 100", {bg_rvalid, sp_rvalid, cpu_rvalid});
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_cpu_write();
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'h12345678;
      sample();
      n_vec++;
      if (cpu_gnt !== 1'b1) begin
         n_err++; $display("FAIL wr_gnt: got %b want 1", cpu_gnt);
      end
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'hFFFF; cpu_wdata = 32'hFFFFFFFF;
      sample();
      n_vec++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 ||
          mem_wdata !== 32'h12345678) begin
         n_err++; $display("FAIL wr_cmd: got en %b we %b addr %h wd %h want 1 1 0010 12345678",
                           mem_en, mem_we, mem_addr, mem_wdata);
      end
      tick();
      sample();
      n_vec++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0010 ||
          mem_wdata !== 32'h12345678) begin
         n_err++; $display("FAIL wr_hold: got en %b we %b addr %h wd %h want 0 0 0010 12345678",
                           mem_en, mem_we, mem_addr, mem_wdata);
      end
      for (int c = 2; c < 5; c++) begin
         n_vec++;
         if (cpu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL wr_no_rvalid c%0d: got %b want 0", c, cpu_rvalid);
         end
         tick();
         sample();
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      do_reset();
      bg_req = 1'b1; bg_addr = 16'h0ABC;
      sample();
      n_vec++;
      if (bg_gnt !== 1'b1) begin
         n_err++; $display("FAIL mr_gnt_c0: got %b want 1", bg_gnt);
      end
      tick();
      bg_req = 1'b0; rst = 1'b1; sp_req = 1'b1;
      sample();
      n_vec++;
      if (sp_gnt !== 1'b0) begin
         n_err++; $display("FAIL mr_gnt_in_rst: got %b want 0", sp_gnt);
      end
      tick();
      rst = 1'b0; sp_req = 1'b0;
      sample();
      n_vec++;
      if ({bg_rvalid, sp_rvalid, cpu_rvalid, mem_en, mem_we} !== 5'b00000 ||
          mem_addr !== 16'h0000 || mem_wdata !== 32'h0) begin
         n_err++; $display("FAIL mr_c2: got v %b en %b we %b addr %h wd %h want 000 0 0 0000 0",
                           {bg_rvalid, sp_rvalid, cpu_rvalid}, mem_en, mem_we, mem_addr, mem_wdata);
      end
      tick();
      bg_req = 1'b1; bg_addr = 16'h0DEF; mem_dout = 32'h0BADF00D;
      sample();
      n_vec++;
      if (bg_gnt !== 1'b1 || bg_rvalid !== 1'b0) begin
         n_err++; $display("FAIL mr_c3: got gnt %b v %b want 1 0", bg_gnt, bg_rvalid);
      end
      tick();
      bg_req = 1'b0;
      sample();
      n_vec++;
      if (mem_en !== 1'b1 || mem_addr !== 16'h0DEF) begin
         n_err++; $display("FAIL mr_c4: got en %b addr %h want 1 0def", mem_en, mem_addr);
      end
      tick();
      sample();
      n_vec++;
      if (bg_rvalid !== 1'b1 || bg_rdata !== 32'h0BADF00D) begin
         n_err++; $display("FAIL mr_c5: got v %b d %h want 1 0badf00d", bg_rvalid, bg_rdata);
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      test_reset();
      test_bg_read();
      test_single_requester();
      test_round_robin();
      test_starvation();
      test_vblank_cpu();
      test_cpu_write();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_vpu_tile_arbiter

// File: doc/vpu_tile_arbiter.md
Name: vpu_tile_arbiter

Overview:
- Shares one single-port tile RAM between three requesters: the BG fetcher (read), the SP fetcher (read) and the CPU/host bus (read/write).
- Sits between vpu_bg, vpu_sp, the CPU VRAM window and the tile RAM macro inside the VPU.
- Arbitration depends on the display phase: video fetchers take priority during active display, the CPU during vblank.
- A starvation counter keeps the CPU serviced during active display.

Parameters:
ADDR_W, 16, tile RAM address width (matches TILE_ADDR_W)
DATA_W, 32, tile RAM data width (matches TILE_DATA_W)
RD_LAT, 1, tile RAM read latency in cycles from the sampled mem_en edge to valid mem_dout (legal range 1..4)
CPU_STARVE_MAX, 15, number of consecutive waiting cycles after which a pending CPU request is force-granted

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
vblank  in  1  1 = vertical blank period, from the VPU timing counter
bg_req  in  1  BG read request; held until bg_gnt
bg_addr  in  ADDR_W  BG read address
bg_gnt  out  1  BG request accepted this cycle
bg_rvalid  out  1  BG read data valid
bg_rdata  out  DATA_W  BG read data
sp_req, sp_addr, sp_gnt, sp_rvalid, sp_rdata  same as BG, for the sprite fetcher
cpu_req  in  1  CPU request; held until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU request accepted
cpu_rvalid  out  1  CPU read data valid (never asserted for writes)
cpu_rdata  out  DATA_W  CPU read data
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM read data

Behaviour:
- Grants:
  - Combinational from the current req inputs and registered state.
  - At most one grant per cycle.
  - All grants are 0 while rst=1.
- Command stage: registered. The cycle after a grant, mem_en=1 and mem_addr/mem_we/mem_wdata carry the granted request. With no grant, the next cycle has mem_en=0, mem_we=0, and addr/wdata hold.
- Read latency:
  - Data for a read granted in cycle N appears in cycle N+1+RD_LAT, with <x>_rvalid=1 for exactly one cycle.
  - Default total latency is 2 cycles.
  - Throughput is one access per cycle.
- Read data: all three rdata outputs are driven directly by mem_dout and are meaningful only while the matching rvalid is 1.
- Response routing: a tag shift register RD_LAT+1 deep carries {valid, id[1:0]} for each read. id encoding: 0 = BG, 1 = SP, 2 = CPU. CPU writes insert no valid tag.
- Round-robin pointer rr (1 bit) between BG and SP:
  - Reset value 0, meaning BG is favoured.
  - On a BG grant rr becomes 1; on an SP grant it becomes 0.
  - When only one of BG/SP requests, that one wins regardless of rr.
- Priority when vblank=0:
  - A forced CPU grant (see starvation counter) wins first.
  - Otherwise BG/SP by round-robin.
  - Otherwise the CPU.
- Priority when vblank=1:
  - CPU first.
  - Otherwise BG/SP by round-robin.
- Starvation counter starve_cnt:
  - Increments each cycle that cpu_req=1 and cpu_gnt=0, saturating at CPU_STARVE_MAX.
  - Clears to 0 on cpu_gnt or when cpu_req=0.
  - Force condition: starve_cnt==CPU_STARVE_MAX and cpu_req=1.
- vblank changes take effect on arbitration in the same cycle; in-flight tags are unaffected.
- Reset values:
  - gnt and rvalid outputs: 0.
  - mem_en, mem_we: 0.
  - mem_addr, mem_wdata: 0.
  - Tag pipe: all invalid.
  - rr: 0; starve_cnt: 0.
- Reset mid-operation: in-flight reads are discarded with no rvalid from the cycle after rst rises. Requesters re-issue.
- A request deasserted without a grant is legal and is simply dropped from arbitration.

Decomposition:
- From gameconsole_pkg: TILE_ADDR_W and TILE_DATA_W.
- Add to gameconsole_pkg: the requester-id enum vram_req_id_e (REQ_BG, REQ_SP, REQ_CPU) and the constant VRAM_CPU_STARVE_MAX.
- One natural sub-module, vpu_rd_tag_pipe: a parameterised RD_LAT+1 deep valid/id shift register that decodes the three rvalid outputs.

Test Plan:
1. Reset then bg_req=1, bg_addr=0x0123, mem_dout preloaded with 0xDEADBEEF (RD_LAT=1) -> bg_gnt in cycle 0; mem_en=1 with mem_addr=0x0123 in cycle 1; bg_rvalid=1 with bg_rdata=0xDEADBEEF in cycle 2; sp_rvalid and cpu_rvalid stay 0.
2. bg_req and sp_req held high for 6 cycles, vblank=0 -> grants alternate BG,SP,BG,SP,BG,SP starting with BG; the rvalid sequence matches, 2 cycles later.
3. vblank=0 with bg_req, sp_req and cpu_req all held -> cpu_gnt stays 0 for cycles 0..14 and asserts in cycle 15; starve_cnt returns to 0; BG/SP alternation resumes in cycle 16.
4. vblank=1 with all three requesting, CPU read of 0x0040 -> cpu_gnt in cycle 0 and cpu_rvalid in cycle 2; BG/SP are granted only after cpu_req drops.
5. CPU write cpu_we=1, addr 0x0010, wdata 0x12345678 -> in cycle 1 mem_we=1, mem_addr=0x0010, mem_wdata=0x12345678; cpu_rvalid is never asserted.
6. BG read granted in cycle 0, rst=1 in cycle 1 for one cycle -> no bg_rvalid in cycle 2; all outputs at their reset values in cycle 2; a new bg_req in cycle 3 is granted normally.
